// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM states, iteration count and an operand-magnitude helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } mdu_state_e;

  localparam int unsigned MDU_ITER = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-division step on the {remainder, dividend} shift register.
// A zero divisor always subtracts, giving an all-ones quotient and remainder = dividend.
module mdu_div_core (
  input  logic [63:0] rem_i,
  input  logic [31:0] divisor_i,
  output logic [63:0] rem_o
);

  logic [32:0] top_s;
  logic [32:0] diff_s;
  logic        ge_s;

  assign top_s  = rem_i[63:31];
  assign ge_s   = (top_s >= {1'b0, divisor_i});
  assign diff_s = top_s - {1'b0, divisor_i};

  // Shift left, then subtract the divisor when it fits and record a quotient 1.
  always_comb begin
    rem_o = {rem_i[62:0], 1'b0};
    if (ge_s) begin
      rem_o = {diff_s[31:0], rem_i[30:0], 1'b1};
    end else begin
      rem_o = {rem_i[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit (33-edge latency).
// Divide support (mdu_div_core) is built only when MDU_DIV_EN is defined.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cancel,
  input  logic [2:0]  md_op,
  input  logic [31:0] data_in1,
  input  logic [31:0] data_in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] LAST_CNT = 6'(MDU_ITER - 1);

  mdu_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        sgn_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_step_s;
  logic [63:0] prod_s;

`ifdef MDU_DIV_EN
  logic        is_div_q, is_div_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] div_step_s;

  mdu_div_core u_div_core (
    .rem_i     (acc_q),
    .divisor_i (opb_q),
    .rem_o     (div_step_s)
  );
`endif

  // Even encodings (MULT, DIV) are the signed variants.
  assign sgn_s   = ~md_op[0];
  assign a_mag_s = abs32(data_in1, sgn_s);
  assign b_mag_s = abs32(data_in2, sgn_s);

  // Shift-add: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum_s  = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
  assign mul_step_s = acc_q[0] ? {mul_sum_s, acc_q[31:1]} : {1'b0, acc_q[63:1]};
  assign prod_s     = neg_q ? (~acc_q + 64'd1) : acc_q;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (start) begin
          case (md_op_e'(md_op))
            OP_MULT, OP_MULTU: begin
              acc_d   = {32'd0, b_mag_s};
              opb_d   = a_mag_s;
              neg_d   = sgn_s & (data_in1[31] ^ data_in2[31]);
              cnt_d   = 6'd0;
              state_d = ST_CALC;
`ifdef MDU_DIV_EN
              is_div_d  = 1'b0;
              neg_rem_d = 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              acc_d     = {32'd0, a_mag_s};
              opb_d     = b_mag_s;
              // Divide by zero keeps the raw all-ones quotient.
              neg_d     = sgn_s & (data_in1[31] ^ data_in2[31]) & (data_in2 != 32'd0);
              neg_rem_d = sgn_s & data_in1[31];
              is_div_d  = 1'b1;
              cnt_d     = 6'd0;
              state_d   = ST_CALC;
            end
`endif
            OP_MTHI: hi_d = data_in1;
            OP_MTLO: lo_d = data_in1;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
`ifdef MDU_DIV_EN
          acc_d = is_div_q ? div_step_s : mul_step_s;
`else
          acc_d = mul_step_s;
`endif
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_SIGN;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_SIGN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            lo_d = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
          end else begin
            hi_d = prod_s[63:32];
            lo_d = prod_s[31:0];
          end
`else
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
`endif
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      opb_q   <= 32'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; divide checks depend on MDU_DIV_EN.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cancel;
  logic [2:0]  md_op;
  logic [31:0] data_in1;
  logic [31:0] data_in2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run;
  int tests_failed;

  mult_div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cancel   (cancel),
    .md_op    (md_op),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op; optionally inject a start (MTHI) or cancel at a given edge.
  // Returns edges from start to done (60 = no done) and number of busy-high samples.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int start_at, input int cancel_at,
                        output int lat, output int busy_cnt);
    md_op = op; data_in1 = a; data_in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      if (lat == start_at - 1) begin
        start = 1'b1; md_op = 3'b100; data_in1 = 32'hDEADBEEF;
      end
      if (lat == cancel_at - 1) cancel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      lat++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%0b done=%0b hi=%h lo=%h, need all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_mult();
    int lat, bc;
    run_op(3'b000, 32'hFFFFFFFE, 32'h00000003, -1, -1, lat, bc);
    tests_run++;
    if (lat !== 33) begin tests_failed++; $display("FAIL mult_latency: got %0d need 33", lat); end
    tests_run++;
    if (bc !== 33) begin tests_failed++; $display("FAIL mult_busy_cycles: got %0d need 33", bc); end
    tests_run++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      tests_failed++; $display("FAIL mult_neg: got %h_%h need ffffffff_fffffffa", hi, lo);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL done_pulse_width: got done=%0b busy=%0b need 0 0", done, busy);
    end
    run_op(3'b000, 32'h00000007, 32'hFFFFFFFB, -1, -1, lat, bc);
    tests_run++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFDD) begin
      tests_failed++; $display("FAIL mult_7x-5: got %h_%h need ffffffff_ffffffdd", hi, lo);
    end
  endtask

  task automatic test_multu();
    int lat, bc;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, lat, bc);
    tests_run++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      tests_failed++; $display("FAIL multu_max: got %h_%h need fffffffe_00000001", hi, lo);
    end
    run_op(3'b001, 32'h12345678, 32'h00000010, -1, -1, lat, bc);
    tests_run++;
    if (hi !== 32'h00000001 || lo !== 32'h23456780) begin
      tests_failed++; $display("FAIL multu_shift: got %h_%h need 00000001_23456780", hi, lo);
    end
  endtask

  task automatic test_move();
    md_op = 3'b101; data_in1 = 32'h12345678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (lo !== 32'h12345678 || hi !== 32'h00000001 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mtlo: got lo=%h hi=%h busy=%0b done=%0b need 12345678 00000001 0 0", lo, hi, busy, done);
    end
    md_op = 3'b100; data_in1 = 32'hCAFEBABE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (hi !== 32'hCAFEBABE || lo !== 32'h12345678 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL mthi: got hi=%h lo=%h busy=%0b need cafebabe 12345678 0", hi, lo, busy);
    end
  endtask

  task automatic test_div();
    int lat, bc;
`ifdef MDU_DIV_EN
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, -1, -1, lat, bc);
    tests_run++;
    if (lat !== 33 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      tests_failed++; $display("FAIL div_-7/2: got lat=%0d lo=%h hi=%h need 33 fffffffd ffffffff", lat, lo, hi);
    end
    run_op(3'b011, 32'h00000007, 32'h00000000, -1, -1, lat, bc);
    tests_run++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'h00000007) begin
      tests_failed++; $display("FAIL divu_by_zero: got lo=%h hi=%h need ffffffff 00000007", lo, hi);
    end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, -1, -1, lat, bc);
    tests_run++;
    if (lo !== 32'h80000000 || hi !== 32'h00000000) begin
      tests_failed++; $display("FAIL div_overflow: got lo=%h hi=%h need 80000000 00000000", lo, hi);
    end
    run_op(3'b011, 32'd100, 32'd7, -1, -1, lat, bc);
    tests_run++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      tests_failed++; $display("FAIL divu_100/7: got lo=%h hi=%h need 0000000e 00000002", lo, hi);
    end
    run_op(3'b010, 32'h00000007, 32'hFFFFFFFE, -1, -1, lat, bc);
    tests_run++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
      tests_failed++; $display("FAIL div_7/-2: got lo=%h hi=%h need fffffffd 00000001", lo, hi);
    end
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000000, -1, -1, lat, bc);
    tests_run++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin
      tests_failed++; $display("FAIL div_neg_by_zero: got lo=%h hi=%h need ffffffff fffffff9", lo, hi);
    end
`else
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    md_op = 3'b010; data_in1 = 32'd9; data_in2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy || done) bc++;
      @(posedge clk); #1;
    end
    lat = bc;
    tests_run++;
    if (lat !== 0 || hi !== hi0 || lo !== lo0) begin
      tests_failed++; $display("FAIL div_disabled: got active_cycles=%0d hi=%h lo=%h need 0 %h %h", lat, hi, lo, hi0, lo0);
    end
`endif
  endtask

  task automatic test_start_while_busy();
    int lat, bc;
    run_op(3'b000, 32'd3, 32'd5, 10, -1, lat, bc);
    tests_run++;
    if (lat !== 33 || hi !== 32'd0 || lo !== 32'd15) begin
      tests_failed++; $display("FAIL start_while_busy: got lat=%0d hi=%h lo=%h need 33 00000000 0000000f", lat, hi, lo);
    end
  endtask

  task automatic test_cancel();
    int lat, bc;
    run_op(3'b001, 32'd100, 32'd100, -1, 20, lat, bc);
    tests_run++;
    if (lat !== 60 || bc !== 20 || hi !== 32'd0 || lo !== 32'd15) begin
      tests_failed++; $display("FAIL cancel_calc: got lat=%0d busy_cycles=%0d hi=%h lo=%h need 60 20 0 f", lat, bc, hi, lo);
    end
    run_op(3'b001, 32'd100, 32'd100, -1, 33, lat, bc);
    tests_run++;
    if (lat !== 60 || bc !== 33 || lo !== 32'd15) begin
      tests_failed++; $display("FAIL cancel_sign: got lat=%0d busy_cycles=%0d lo=%h need 60 33 f", lat, bc, lo);
    end
    md_op = 3'b101; data_in1 = 32'hAAAA5555; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (lo !== 32'd15 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL cancel_beats_mtlo: got lo=%h busy=%0b need 0000000f 0", lo, busy);
    end
    md_op = 3'b000;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL cancel_beats_mult: got busy=%0b need 0", busy);
    end
  endtask

  task automatic test_illegal();
    md_op = 3'b110; data_in1 = 32'h11111111; start = 1'b1;
    @(posedge clk); #1;
    md_op = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd15) begin
      tests_failed++; $display("FAIL illegal_op: got busy=%0b hi=%h lo=%h need 0 0 f", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(3'b001, 32'd6, 32'd7, -1, -1, lat, bc);
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, lat, bc);
    tests_run++;
    if (lat !== 33 || hi !== 32'd0 || lo !== 32'd1) begin
      tests_failed++; $display("FAIL back_to_back: got lat=%0d hi=%h lo=%h need 33 0 1", lat, hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int bad;
`ifdef MDU_DIV_EN
    md_op = 3'b010;
`else
    md_op = 3'b000;
`endif
    data_in1 = 32'd1000; data_in2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      tests_failed++; $display("FAIL reset_mid_op: got busy=%0b done=%0b hi=%h lo=%h need all 0", busy, done, hi, lo);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy || done) bad++;
    end
    tests_run++;
    if (bad !== 0 || lo !== 32'd0) begin
      tests_failed++; $display("FAIL after_reset_release: got active_cycles=%0d lo=%h need 0 0", bad, lo);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0;
    md_op = 3'b000; data_in1 = 32'd0; data_in2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_mult();
    test_multu();
    test_move();
    test_div();
    test_start_while_busy();
    test_cancel();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
